// File: rtl/ms_tmr_nch_apb.sv
// APB peripheral with NCH independent timer/PWM channels and one shared prescaler.
// Each channel counts up or down, in periodic or one-shot mode, and flags a
// compare match. PERIOD and CMP writes go to shadow registers, which are copied
// to the active registers on the channel wrap, so PWM edits are glitch-free.
module ms_tmr_nch_apb #(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int PSC_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [NCH-1:0] pwm_out,
  output logic           irq
);

  localparam int         NB    = 2 * NCH;
  localparam logic [4:0] NCH_L = 5'(NCH);

  typedef enum logic [1:0] {R_COUNT, R_PERIOD, R_CMP, R_CTRL} ch_reg_e;

  // CTRL layout, MSB first: [4] POL, [3] PWM_EN, [2] DOWN, [1] ONESHOT, [0] EN
  typedef struct packed {
    logic pol;
    logic pwm_en;
    logic down;
    logic oneshot;
    logic en;
  } ctrl_t;

  logic [W-1:0]     count      [NCH];
  logic [W-1:0]     period_sh  [NCH];
  logic [W-1:0]     period_act [NCH];
  logic [W-1:0]     cmp_sh     [NCH];
  logic [W-1:0]     cmp_act    [NCH];
  ctrl_t            ctrl       [NCH];
  logic [PSC_W-1:0] psc, psc_cnt;
  logic [NB-1:0]    ris, im, ris_set, ris_clr;

  logic             acc, wr, tick;
  logic [11:0]      addr;
  logic [3:0]       ch_idx;
  ch_reg_e          ch_reg;
  logic             in_ch, is_psc, is_ris, is_mis, is_im, is_icr, mapped;
  logic [NCH-1:0]   ch_wr, run, wrap;
  logic [W-1:0]     wdata;
  ctrl_t            wctrl;
  logic             unused_bits;

  assign wdata       = PWDATA[W-1:0];
  assign wctrl       = ctrl_t'(PWDATA[4:0]);
  assign tick        = (psc_cnt == psc);
  assign PREADY      = 1'b1;
  assign PSLVERR     = acc & ~mapped;
  assign irq         = |(ris & im);
  assign unused_bits = ^{PADDR[31:12], PWDATA};

  // Address decode of the current APB access.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path can leave it unassigned and infer a latch.
    acc    = PSEL & PENABLE;
    wr     = acc & PWRITE;
    addr   = PADDR[11:0];
    ch_idx = addr[7:4];
    ch_reg = ch_reg_e'(addr[3:2]);
    in_ch  = (addr[11:8] == 4'd0) && (addr[1:0] == 2'd0) && ({1'b0, ch_idx} < NCH_L);
    is_psc = (addr == 12'h100);
    is_ris = (addr == 12'h200);
    is_mis = (addr == 12'h204);
    is_im  = (addr == 12'h208);
    is_icr = (addr == 12'h20C);
    mapped = in_ch | is_psc | is_ris | is_mis | is_im | is_icr;
  end

  // Per-channel strobes: register write, count step, wrap condition, flag sets.
  always_comb begin
    ch_wr   = '0;
    run     = '0;
    wrap    = '0;
    ris_set = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_wr[i]       = wr & in_ch & (ch_idx == 4'(i));
      run[i]         = tick & ctrl[i].en;
      wrap[i]        = ctrl[i].down ? (count[i] == '0) : (count[i] == period_act[i]);
      ris_set[2*i]   = run[i] & wrap[i];
      ris_set[2*i+1] = run[i] & (count[i] == cmp_act[i]);
    end
    ris_clr = (wr && is_icr) ? PWDATA[NB-1:0] : '0;
  end

  // Read mux; unmapped addresses return a recognisable pattern.
  always_comb begin
    PRDATA = 32'hDEADBEEF;
    if (in_ch) begin
      PRDATA = '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (ch_reg)
            R_COUNT:  PRDATA[W-1:0] = count[i];
            R_PERIOD: PRDATA[W-1:0] = period_sh[i];
            R_CMP:    PRDATA[W-1:0] = cmp_sh[i];
            R_CTRL:   PRDATA[4:0]   = ctrl[i];
            default:  PRDATA        = '0;
          endcase
        end
      end
    end else if (is_psc) begin
      PRDATA              = '0;
      PRDATA[PSC_W-1:0]   = psc;
    end else if (is_ris) begin
      PRDATA              = '0;
      PRDATA[NB-1:0]      = ris;
    end else if (is_mis) begin
      PRDATA              = '0;
      PRDATA[NB-1:0]      = ris & im;
    end else if (is_im) begin
      PRDATA              = '0;
      PRDATA[NB-1:0]      = im;
    end else if (is_icr) begin
      PRDATA              = '0;
    end
  end

  // Shared prescaler: tick in the cycle psc_cnt reaches PSC; a PSC write restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else if (wr && is_psc) begin
      psc     <= PWDATA[PSC_W-1:0];
      psc_cnt <= '0;
    end else if (tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  // Channel state: shadow/active registers, counter, control and PWM output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: these arrays are per-channel flops rather than RAM, so they can and must be cleared by reset.
      for (int i = 0; i < NCH; i++) begin
        count[i]      <= '0;
        period_sh[i]  <= '0;
        period_act[i] <= '0;
        cmp_sh[i]     <= '0;
        cmp_act[i]    <= '0;
        ctrl[i]       <= '0;
        pwm_out[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_wr[i] && ch_reg == R_PERIOD) begin
          period_sh[i] <= wdata;
          if (!ctrl[i].en) period_act[i] <= wdata;
        end else if (!ctrl[i].en || (run[i] && wrap[i])) begin
          period_act[i] <= period_sh[i];
        end

        if (ch_wr[i] && ch_reg == R_CMP) begin
          cmp_sh[i] <= wdata;
          if (!ctrl[i].en) cmp_act[i] <= wdata;
        end else if (!ctrl[i].en || (run[i] && wrap[i])) begin
          cmp_act[i] <= cmp_sh[i];
        end

        if (ch_wr[i] && ch_reg == R_CTRL && wctrl.en && !ctrl[i].en) begin
          count[i] <= wctrl.down ? period_act[i] : '0;
        end else if (run[i]) begin
          if (!wrap[i])               count[i] <= ctrl[i].down ? count[i] - 1'b1 : count[i] + 1'b1;
          else if (!ctrl[i].oneshot)  count[i] <= ctrl[i].down ? period_sh[i] : '0;
        end

        if (ch_wr[i] && ch_reg == R_CTRL) begin
          ctrl[i] <= wctrl;
        end else if (run[i] && wrap[i] && ctrl[i].oneshot) begin
          ctrl[i].en <= 1'b0;
        end

        pwm_out[i] <= ctrl[i].pwm_en ? ((count[i] < cmp_act[i]) ^ ctrl[i].pol) : ctrl[i].pol;
      end
    end
  end

  // Interrupt flags: hardware set takes priority over a write-1-clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ris <= '0;
      im  <= '0;
    end else begin
      ris <= (ris & ~ris_clr) | ris_set;
      if (wr && is_im) im <= PWDATA[NB-1:0];
    end
  end

endmodule

// File: tb/tb_ms_tmr_nch_apb.sv
// Self-checking bench for ms_tmr_nch_apb: a register-access vector table, then
// hand-written timing sequences for counting, one-shot, shadow reload, IRQ
// set/clear priority, concurrent channels and asynchronous reset.
module tb_ms_tmr_nch_apb;

  localparam int NCH   = 4;
  localparam int W     = 32;
  localparam int PSC_W = 8;

  logic           clk     = 1'b0;
  logic           rst     = 1'b1;
  logic           psel    = 1'b0;
  logic           penable = 1'b0;
  logic           pwrite  = 1'b0;
  logic [31:0]    paddr   = '0;
  logic [31:0]    pwdata  = '0;
  logic [31:0]    prdata;
  logic           pready, pslverr, irq;
  logic [NCH-1:0] pwm;

  int n_checks = 0;
  int n_pass   = 0;

  ms_tmr_nch_apb #(.NCH(NCH), .W(W), .PSC_W(PSC_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .pwm_out (pwm),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] e, input bit err);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp_rd = e; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] rd);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; #1; rd = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  // Hold a continuous read of one address so it can be sampled every cycle.
  task automatic monitor(input logic [31:0] a);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;

    // ---------------- register access table ----------------
    for (int n = 0; n < NCH; n++)
      for (int r = 0; r < 4; r++)
        add(0, 32'(n * 16 + r * 4), '0, 32'h0, 0);
    add(0, 32'h100, '0, 32'h0, 0);
    add(0, 32'h200, '0, 32'h0, 0);
    add(0, 32'h204, '0, 32'h0, 0);
    add(0, 32'h208, '0, 32'h0, 0);
    add(0, 32'h20C, '0, 32'h0, 0);
    add(0, 32'h0FC, '0, 32'hDEADBEEF, 1);
    add(0, 32'h040, '0, 32'hDEADBEEF, 1);
    add(0, 32'h102, '0, 32'hDEADBEEF, 1);
    add(0, 32'h300, '0, 32'hDEADBEEF, 1);
    add(1, 32'h024, 32'h12345678, '0, 0);
    add(0, 32'h024, '0, 32'h12345678, 0);
    add(1, 32'h038, 32'hA5A5A5A5, '0, 0);
    add(0, 32'h038, '0, 32'hA5A5A5A5, 0);
    add(1, 32'h01C, 32'hFFFFFFFE, '0, 0);
    add(0, 32'h01C, '0, 32'h0000001E, 0);
    add(1, 32'h100, 32'h000001FF, '0, 0);
    add(0, 32'h100, '0, 32'h000000FF, 0);
    add(1, 32'h208, 32'hFFFFFFFF, '0, 0);
    add(0, 32'h208, '0, 32'h000000FF, 0);
    add(0, 32'h204, '0, 32'h0, 0);
    add(1, 32'h20C, 32'h000000FF, '0, 0);
    add(0, 32'h20C, '0, 32'h0, 0);
    add(1, 32'h000, 32'h00000055, '0, 0);
    add(0, 32'h000, '0, 32'h0, 0);
    add(1, 32'h0FC, 32'h00000001, '0, 1);
    add(0, 32'h0FC, '0, 32'hDEADBEEF, 1);
    add(1, 32'h01C, 32'h0, '0, 0);
    add(1, 32'h100, 32'h0, '0, 0);
    add(1, 32'h208, 32'h0, '0, 0);

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    #1;
    check("reset pwm_out", 32'(pwm), 32'h0);
    check("reset irq",     32'(irq), 32'h0);
    check("pready",        32'(pready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      psel = 1'b1; penable = 1'b0; pwrite = vecs[i].wr;
      paddr = vecs[i].addr; pwdata = vecs[i].data;
      @(negedge clk); penable = 1'b1; #1;
      if (!vecs[i].wr) check($sformatf("rd 0x%03h", vecs[i].addr[11:0]), prdata, vecs[i].exp_rd);
      check($sformatf("%s err 0x%03h", vecs[i].wr ? "wr" : "rd", vecs[i].addr[11:0]),
            32'(pslverr), 32'(vecs[i].exp_err));
      @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    end

    // ---------------- ch0 periodic up count, PWM, TO ----------------
    apb_write(32'h004, 32'd4);
    apb_write(32'h008, 32'd2);
    apb_write(32'h208, 32'h1);
    apb_write(32'h00C, 32'h09);            // EN lands on edge E0
    monitor(32'h000);
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("ch0 count k=%0d", k), prdata, 32'(k % 5));
      exp = (k == 0) ? 32'h0 : 32'((((k - 1) % 5) < 2) ? 1 : 0);
      check($sformatf("ch0 pwm k=%0d", k), 32'(pwm[0]), exp);
      check($sformatf("ch0 irq k=%0d", k), 32'(irq), 32'(k >= 5));
      @(negedge clk);
    end

    // ---------------- ICR vs simultaneous TO ----------------
    repeat (3) @(negedge clk);
    apb_write(32'h20C, 32'h1);             // lands on E15, a TO edge
    #1;
    check("icr vs to: irq stays", 32'(irq), 32'h1);
    apb_write(32'h20C, 32'h1);             // lands on E17, no TO
    #1;
    check("icr clears irq", 32'(irq), 32'h0);
    apb_read(32'h200, rd);
    check("ris after icr", rd, 32'h2);

    // ---------------- ch1 down one-shot with PSC=3 ----------------
    apb_write(32'h00C, 32'h0);
    apb_write(32'h20C, 32'hFF);
    apb_write(32'h208, 32'h0);
    apb_write(32'h014, 32'd2);
    apb_write(32'h100, 32'd3);
    apb_write(32'h01C, 32'h07);
    monitor(32'h010);
    for (int j = 0; j < 14; j++) begin
      #1;
      exp = (j < 2) ? 32'd2 : (j < 6) ? 32'd1 : 32'd0;
      check($sformatf("ch1 count j=%0d", j), prdata, exp);
      @(negedge clk);
    end
    apb_read(32'h01C, rd);
    check("ch1 ctrl en cleared", rd, 32'h06);
    apb_read(32'h200, rd);
    check("ch1 ris to+mt", rd, 32'h0C);
    apb_read(32'h010, rd);
    check("ch1 count held", rd, 32'h0);

    // ---------------- ch0 shadow PERIOD reload ----------------
    apb_write(32'h100, 32'd0);
    apb_write(32'h004, 32'd9);
    apb_write(32'h00C, 32'h01);
    repeat (4) @(negedge clk);
    apb_write(32'h004, 32'd3);             // lands while COUNT=5
    monitor(32'h000);
    for (int j = 6; j < 18; j++) begin
      #1;
      exp = (j <= 9) ? 32'(j) : 32'((j - 10) % 4);
      check($sformatf("ch0 shadow count j=%0d", j), prdata, exp);
      @(negedge clk);
    end

    // ---------------- all channels concurrently, then reset ----------------
    apb_write(32'h00C, 32'h0);
    for (int n = 0; n < NCH; n++) apb_write(32'(n * 16 + 4), 32'(n + 1));
    for (int n = 0; n < NCH; n++) apb_write(32'(n * 16 + 12), 32'h11);
    for (int t = 6; t < 22; t++) begin
      monitor(32'((t % 4) * 16));
      #1;
      check($sformatf("multi ch%0d t=%0d", t % 4, t), prdata,
            32'((t - 2 * (t % 4)) % ((t % 4) + 2)));
      @(negedge clk);
    end
    monitor(32'h030);
    #1;
    check("ch3 count before reset", prdata, 32'd1);
    check("pwm before reset", 32'(pwm), 32'hF);
    rst = 1'b1;
    #1;
    check("ch3 count in reset", prdata, 32'h0);
    check("pwm in reset", 32'(pwm), 32'h0);
    check("irq in reset", 32'(irq), 32'h0);
    paddr = 32'h03C;
    #1;
    check("ch3 ctrl in reset", prdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    psel = 1'b0; penable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
